// File: rtl/rx_nrzi_decoder_if.sv
// Line-side inputs and unstuffer-side strobes of the receive NRZI front end.
// The decoder uses the slave view; whoever drives the line uses the master view.
interface rx_nrzi_decoder_if;
    logic dp;
    logic dm;
    logic s_out;
    logic start_unstuffer;
    logic end_unstuffer;
    logic pkt_done;
    logic sync_error;
    logic eop_error;
    logic rx_error;

    modport master (
        output dp,
        output dm,
        input  s_out,
        input  start_unstuffer,
        input  end_unstuffer,
        input  pkt_done,
        input  sync_error,
        input  eop_error,
        input  rx_error
    );

    modport slave (
        input  dp,
        input  dm,
        output s_out,
        output start_unstuffer,
        output end_unstuffer,
        output pkt_done,
        output sync_error,
        output eop_error,
        output rx_error
    );
endinterface

// File: rtl/rx_nrzi_decoder.sv
// Receive line front end: samples dp/dm, finds SYNC, NRZI-decodes packet bits,
// checks EOP and feeds the bit unstuffer with serial data plus start/end strobes.
module rx_nrzi_decoder #(
    parameter int MAX_BITS = 1100,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    rx_nrzi_decoder_if.slave rx
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_PACKET = 3'd2,
        ST_EOP1   = 3'd3,
        ST_EOP2   = 3'd4,
        ST_ABORT  = 3'd5
    } state_t;

    localparam logic [1:0]       LINE_J   = 2'b10;
    localparam logic [1:0]       LINE_K   = 2'b01;
    localparam logic [1:0]       LINE_SE0 = 2'b00;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BITS);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_line;
    logic [1:0]       r_prev;
    logic [2:0]       r_trans_cnt;
    logic [2:0]       w_trans_cnt_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_next;

    logic r_s_out, r_start, r_end, r_done, r_sync_err, r_eop_err, r_rx_err;
    logic w_s_out, w_start, w_end, w_done, w_sync_err, w_eop_err, w_rx_err;

    logic w_is_jk;
    logic w_same;
    logic w_sync_step;
    logic w_sync_done;
    logic w_bits_full;
    logic w_has_bits;

    // r_line is the current sample, r_prev the one before it (any line state)
    assign w_is_jk     = r_line[1] ^ r_line[0];
    assign w_same      = (r_line == r_prev);
    assign w_sync_step = w_is_jk && !w_same && (r_trans_cnt != 3'd7);
    assign w_sync_done = (r_line == LINE_K) && w_same && (r_trans_cnt == 3'd7);
    assign w_bits_full = (r_bit_cnt == MAX_CNT);
    assign w_has_bits  = (r_bit_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_line      <= LINE_J;
            r_prev      <= LINE_J;
            r_trans_cnt <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_line      <= {rx.dp, rx.dm};
            r_prev      <= r_line;
            r_trans_cnt <= w_trans_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_trans_cnt_next = r_trans_cnt;
        w_bit_cnt_next   = r_bit_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_line == LINE_K && r_prev == LINE_J) begin
                    w_state_next     = ST_SYNC;
                    w_trans_cnt_next = 3'd1;
                end
            end
            ST_SYNC: begin
                if (w_sync_step) begin
                    w_trans_cnt_next = r_trans_cnt + 3'd1;
                end else if (w_sync_done) begin
                    w_state_next   = ST_PACKET;
                    w_bit_cnt_next = '0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PACKET: begin
                if (w_is_jk) begin
                    if (w_bits_full) begin
                        w_state_next = ST_ABORT;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end else if (r_line == LINE_SE0) begin
                    w_state_next = ST_EOP1;
                end else begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_EOP1: begin
                if (r_line == LINE_SE0) begin
                    w_state_next = ST_EOP2;
                end else if (r_line == LINE_J) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_EOP2: begin
                w_state_next = (r_line == LINE_J) ? ST_IDLE : ST_ABORT;
            end
            ST_ABORT: begin
                // Only a completed SE0 -> J return to idle re-arms the receiver
                if (r_line == LINE_J && r_prev == LINE_SE0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_s_out    = 1'b0;
        w_start    = 1'b0;
        w_end      = 1'b0;
        w_done     = 1'b0;
        w_sync_err = 1'b0;
        w_eop_err  = 1'b0;
        w_rx_err   = 1'b0;
        case (r_state)
            ST_SYNC: begin
                w_sync_err = !w_sync_step && !w_sync_done;
            end
            ST_PACKET: begin
                if (w_is_jk && !w_bits_full) begin
                    w_s_out = w_same;
                    w_start = !w_has_bits;
                end else if (r_line == LINE_SE0) begin
                    // An empty packet never opened the unstuffer, so it is not closed
                    w_end    = w_has_bits;
                    w_rx_err = !w_has_bits;
                end else begin
                    w_end    = w_has_bits;
                    w_rx_err = 1'b1;
                end
            end
            ST_EOP1: begin
                w_eop_err = (r_line != LINE_SE0);
            end
            ST_EOP2: begin
                w_done    = (r_line == LINE_J) && w_has_bits;
                w_eop_err = (r_line != LINE_J);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_out    <= 1'b0;
            r_start    <= 1'b0;
            r_end      <= 1'b0;
            r_done     <= 1'b0;
            r_sync_err <= 1'b0;
            r_eop_err  <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_s_out    <= w_s_out;
            r_start    <= w_start;
            r_end      <= w_end;
            r_done     <= w_done;
            r_sync_err <= w_sync_err;
            r_eop_err  <= w_eop_err;
            r_rx_err   <= w_rx_err;
        end
    end

    assign rx.s_out           = r_s_out;
    assign rx.start_unstuffer = r_start;
    assign rx.end_unstuffer   = r_end;
    assign rx.pkt_done        = r_done;
    assign rx.sync_error      = r_sync_err;
    assign rx.eop_error       = r_eop_err;
    assign rx.rx_error        = r_rx_err;
endmodule

// File: tb/tb_rx_nrzi_decoder.sv
// Bench for rx_nrzi_decoder: a table-driven clean packet, directed corner cases and
// random line streams, all compared cycle by cycle against a stream-parser model.
module tb_rx_nrzi_decoder;
    localparam int MAXB = 16;
    localparam int NMAX = 1024;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LSE1 = 2'b11;

    // expected vector bit order: {s_out, start, end, pkt_done, sync_err, eop_err, rx_err}
    typedef struct {
        logic [1:0] line;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rx_nrzi_decoder_if bus ();

    rx_nrzi_decoder #(.MAX_BITS(MAXB), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus)
    );

    always #5 clk = ~clk;

    logic [1:0] sym  [NMAX];
    logic [6:0] expv [NMAX];
    int n;
    int n_checks = 0;
    int n_fail   = 0;
    int c_start, c_end, c_done, c_serr, c_eerr, c_rerr;
    int i_start, i_end, i_done, i_serr;

    function automatic logic [1:0] prv(input int i);
        return (i == 0) ? LJ : sym[i-1];
    endfunction

    function automatic bit is_jk(input logic [1:0] s);
        return s == LJ || s == LK;
    endfunction

    task automatic push(input logic [1:0] s);
        if (n < NMAX) begin
            sym[n] = s;
            n++;
        end
    endtask

    task automatic push_sync();
        push(LK); push(LJ); push(LK); push(LJ);
        push(LK); push(LJ); push(LK); push(LK);
    endtask

    task automatic push_bits(input int len);
        for (int k = 0; k < len; k++) push(($urandom_range(0, 1) == 1) ? LJ : LK);
    endtask

    task automatic push_eop();
        push(LSE0); push(LSE0); push(LJ);
    endtask

    // Walks the sample stream as a parser: idle scan, SYNC match, packet body, EOP, abort
    task automatic model();
        int i, t, bits, nxt;
        bit ok;
        for (int k = 0; k < n; k++) expv[k] = '0;
        i = 0;
        while (i < n) begin
            if (!(sym[i] == LK && prv(i) == LJ)) begin
                i++;
                continue;
            end
            t = 1; i++; ok = 0;
            while (i < n) begin
                if (is_jk(sym[i]) && sym[i] != prv(i) && t < 7) begin
                    t++; i++;
                end else if (sym[i] == LK && prv(i) == LK && t == 7) begin
                    ok = 1; i++;
                    break;
                end else begin
                    expv[i][2] = 1'b1; i++;
                    break;
                end
            end
            if (!ok) continue;
            bits = 0; nxt = 0;
            while (i < n) begin
                if (is_jk(sym[i]) && bits < MAXB) begin
                    expv[i][6] = (sym[i] == prv(i));
                    expv[i][5] = (bits == 0);
                    bits++; i++;
                end else if (sym[i] == LSE0) begin
                    if (bits > 0) expv[i][4] = 1'b1;
                    else expv[i][0] = 1'b1;
                    i++; nxt = 1;
                    break;
                end else begin
                    expv[i][4] = (bits > 0);
                    expv[i][0] = 1'b1;
                    i++; nxt = 2;
                    break;
                end
            end
            if (nxt == 1 && i < n) begin
                if (sym[i] == LSE0) begin
                    i++;
                    if (i < n) begin
                        if (sym[i] == LJ) begin
                            expv[i][3] = (bits > 0);
                            nxt = 0;
                        end else begin
                            expv[i][1] = 1'b1;
                            nxt = 2;
                        end
                        i++;
                    end
                end else begin
                    expv[i][1] = 1'b1;
                    nxt = (sym[i] == LJ) ? 0 : 2;
                    i++;
                end
            end
            if (nxt == 2) begin
                while (i < n) begin
                    if (sym[i] == LJ && prv(i) == LSE0) begin
                        i++;
                        break;
                    end
                    i++;
                end
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.s_out, bus.start_unstuffer, bus.end_unstuffer, bus.pkt_done,
                bus.sync_error, bus.eop_error, bus.rx_error};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {bus.dp, bus.dm} = LJ;
        @(negedge clk);
        rst_n = 1'b1;
        check_int("reset_state", int'(outs()), 0);
    endtask

    task automatic run_stream(input string name);
        logic [6:0] got;
        c_start = 0; c_end = 0; c_done = 0; c_serr = 0; c_eerr = 0; c_rerr = 0;
        i_start = -1; i_end = -1; i_done = -1; i_serr = -1;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                got = outs();
                n_checks++;
                if (got !== expv[i-2]) begin
                    n_fail++;
                    $display("FAIL %s sample %0d: got %b expected %b", name, i - 2, got, expv[i-2]);
                end
                if (got[5]) begin c_start++; if (i_start < 0) i_start = i - 2; end
                if (got[4]) begin c_end++;   if (i_end < 0)   i_end   = i - 2; end
                if (got[3]) begin c_done++;  if (i_done < 0)  i_done  = i - 2; end
                if (got[2]) begin c_serr++;  if (i_serr < 0)  i_serr  = i - 2; end
                if (got[1]) c_eerr++;
                if (got[0]) c_rerr++;
            end
            {bus.dp, bus.dm} = (i < n) ? sym[i] : LJ;
        end
        $display("stream %s: %0d samples, start=%0d end=%0d done=%0d serr=%0d eerr=%0d rerr=%0d",
                 name, n, c_start, c_end, c_done, c_serr, c_eerr, c_rerr);
    endtask

    vec_t tbl [22];

    initial begin
        {bus.dp, bus.dm} = LJ;

        // Clean OUT token from a hand-written table
        tbl = '{
            '{LJ, 7'b0000000}, '{LJ, 7'b0000000}, '{LJ, 7'b0000000},
            '{LK, 7'b0000000}, '{LJ, 7'b0000000}, '{LK, 7'b0000000}, '{LJ, 7'b0000000},
            '{LK, 7'b0000000}, '{LJ, 7'b0000000}, '{LK, 7'b0000000}, '{LK, 7'b0000000},
            '{LK, 7'b1100000}, '{LJ, 7'b0000000}, '{LK, 7'b0000000}, '{LJ, 7'b0000000},
            '{LK, 7'b0000000}, '{LK, 7'b1000000}, '{LK, 7'b1000000}, '{LK, 7'b1000000},
            '{LSE0, 7'b0010000}, '{LSE0, 7'b0000000}, '{LJ, 7'b0001000}
        };
        do_reset();
        n = 22;
        for (int k = 0; k < 22; k++) begin
            sym[k]  = tbl[k].line;
            expv[k] = tbl[k].exp;
        end
        run_stream("clean_out");
        check_int("clean_start_cnt", c_start, 1);
        check_int("clean_end_to_start", i_end - i_start, 8);
        check_int("clean_done_to_end", i_done - i_end, 2);
        check_int("clean_errors", c_serr + c_eerr + c_rerr, 0);

        // Bad SYNC, then a good packet
        do_reset();
        n = 0;
        push(LJ); push(LK); push(LJ); push(LK); push(LJ); push(LK); push(LK);
        push(LJ); push_sync(); push_bits(2); push_eop();
        model();
        run_stream("bad_sync");
        check_int("bad_sync_serr", c_serr, 1);
        check_int("bad_sync_start", c_start, 1);
        check_int("bad_sync_order", int'(i_serr < i_start), 1);
        check_int("bad_sync_done", c_done, 1);

        // SE1 after five bits; a SYNC inside ABORT is ignored until SE0,J
        do_reset();
        n = 0;
        push(LJ); push_sync(); push_bits(5); push(LSE1);
        push_sync(); push(LK); push(LJ); push(LSE0); push(LJ);
        push_sync(); push_bits(3); push_eop();
        model();
        run_stream("se1_abort");
        check_int("se1_end_to_start", i_end - i_start, 5);
        check_int("se1_rerr", c_rerr, 1);
        check_int("se1_start", c_start, 2);
        check_int("se1_done", c_done, 1);

        // Length overflow: 20 bits into a 16-bit limit
        do_reset();
        n = 0;
        push(LJ); push_sync(); push_bits(20); push(LSE0); push(LJ);
        push_sync(); push_bits(1); push_eop();
        model();
        run_stream("overflow");
        check_int("ovf_bits_emitted", i_end - i_start, 16);
        check_int("ovf_rerr", c_rerr, 1);
        check_int("ovf_end", c_end, 2);
        check_int("ovf_done", c_done, 1);

        // Malformed EOP SE0,J followed at once by SYNC
        do_reset();
        n = 0;
        push(LJ); push_sync(); push_bits(3); push(LSE0); push(LJ);
        push_sync(); push_bits(2); push_eop();
        model();
        run_stream("bad_eop");
        check_int("bad_eop_end_to_start", i_end - i_start, 3);
        check_int("bad_eop_eerr", c_eerr, 1);
        check_int("bad_eop_start", c_start, 2);
        check_int("bad_eop_done", c_done, 1);

        // Empty packet: SYNC then SE0,SE0,J
        do_reset();
        n = 0;
        push(LJ); push_sync(); push_eop(); push(LJ);
        push_sync(); push_bits(2); push_eop();
        model();
        run_stream("empty_pkt");
        check_int("empty_rerr", c_rerr, 1);
        check_int("empty_start", c_start, 1);
        check_int("empty_done", c_done, 1);

        // Reset in the middle of a packet
        do_reset();
        n = 0;
        push(LJ); push_sync(); push_bits(4);
        model();
        run_stream("pre_reset");
        check_int("pre_reset_start", c_start, 1);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_int("post_reset_idle", int'(outs()), 0);
        end
        n = 0;
        push(LJ); push_sync(); push_bits(8); push_eop();
        model();
        run_stream("after_reset");
        check_int("after_reset_start", c_start, 1);
        check_int("after_reset_end", c_end, 1);
        check_int("after_reset_done", c_done, 1);

        // Random streams of well-formed and damaged packets
        for (int r = 0; r < 20; r++) begin
            do_reset();
            n = 0;
            while (n < 500) begin
                push_bits(0);
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) push(LJ);
                if ($urandom_range(0, 7) == 0) begin
                    push(LK);
                    for (int k = 0; k < int'($urandom_range(0, 7)); k++) push((k % 2 == 0) ? LJ : LK);
                    push(2'($urandom_range(0, 3)));
                end else begin
                    push_sync();
                end
                push_bits(int'($urandom_range(0, 21)));
                if ($urandom_range(0, 7) == 0) push(2'($urandom_range(0, 3)));
                case ($urandom_range(0, 5))
                    0, 1, 2: push_eop();
                    3: begin push(LSE0); push(LJ); end
                    4: push(LSE1);
                    default: begin push(LSE0); push(LK); end
                endcase
                push(LSE0); push(LJ);
            end
            model();
            run_stream($sformatf("random_%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
